// File: rtl/blink_sequencer.sv
// Lamp on/off pattern scheduler: four programmable interval slots timed on a
// prescaled tick; even slots light the lamp, odd slots darken it.
module blink_sequencer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] switches,
    input  logic        load,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  nslots,
    input  logic        repeat_en,
    output logic        light,
    output logic        busy,
    output logic [1:0]  slot_idx,
    output logic [1:0]  wr_ptr,
    output logic [13:0] remaining
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [13:0]   slots [4];
    logic [PW-1:0] prescaler, prescaler_n;
    logic [1:0]    nslots_q, nslots_n;
    logic          repeat_q, repeat_n;
    logic [1:0]    slot_idx_n, next_idx;
    logic [13:0]   remaining_n;
    logic          light_n, busy_n;
    logic          tick;

    // A zero interval is still timed as one tick.
    function automatic logic [13:0] slot_len(input logic [13:0] v);
        return (v == 14'd0) ? 14'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 2'd0;
            for (int i = 0; i < 4; i++) slots[i] <= 14'd0;
        end else if (load) begin
            slots[wr_ptr] <= switches;
            wr_ptr        <= wr_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            prescaler <= '0;
            nslots_q  <= 2'd0;
            repeat_q  <= 1'b0;
            slot_idx  <= 2'd0;
            remaining <= 14'd0;
            light     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            prescaler <= prescaler_n;
            nslots_q  <= nslots_n;
            repeat_q  <= repeat_n;
            slot_idx  <= slot_idx_n;
            remaining <= remaining_n;
            light     <= light_n;
            busy      <= busy_n;
        end
    end

    assign tick = (state == RUN) && (prescaler == TICK_LAST);

    // Priority: stop beats start, start beats the tick; start reads slot
    // contents before any same-cycle load lands.
    always_comb begin
        state_n     = state;
        nslots_n    = nslots_q;
        repeat_n    = repeat_q;
        slot_idx_n  = slot_idx;
        remaining_n = remaining;
        light_n     = light;
        busy_n      = busy;
        next_idx    = slot_idx + 2'd1;
        if (state == RUN)
            prescaler_n = tick ? '0 : prescaler + PW'(1);
        else
            prescaler_n = '0;

        if (stop) begin
            if (state == RUN) begin
                state_n     = IDLE;
                prescaler_n = '0;
                slot_idx_n  = 2'd0;
                remaining_n = 14'd0;
                light_n     = 1'b0;
                busy_n      = 1'b0;
            end
        end else if (start) begin
            state_n     = RUN;
            nslots_n    = nslots;
            repeat_n    = repeat_en;
            prescaler_n = '0;
            slot_idx_n  = 2'd0;
            remaining_n = slot_len(slots[0]);
            light_n     = 1'b1;
            busy_n      = 1'b1;
        end else if (tick) begin
            if (remaining > 14'd1) begin
                remaining_n = remaining - 14'd1;
            end else if (slot_idx < nslots_q) begin
                slot_idx_n  = next_idx;
                remaining_n = slot_len(slots[next_idx]);
                light_n     = ~next_idx[0];
            end else if (repeat_q) begin
                slot_idx_n  = 2'd0;
                remaining_n = slot_len(slots[0]);
                light_n     = 1'b1;
            end else begin
                state_n     = IDLE;
                slot_idx_n  = 2'd0;
                remaining_n = 14'd0;
                light_n     = 1'b0;
                busy_n      = 1'b0;
            end
        end
    end

endmodule

// File: doc/blink_sequencer.md
# blink_sequencer

Programmable on/off pattern scheduler for the flashlight lamp output. Holds four interval slots loaded one at a time from the 14-bit switch bank with the debounced set-button pulse. On command it sequences the lamp through the active slots: even slots drive the lamp on, odd slots drive it off. Timing runs on a millisecond tick derived from the system clock. It sits between the button/switch front end and the lamp, and exposes the remaining count for the seven-segment display path.

## Interface
- TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz); must be ≥2
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- switches  in  14  interval value in ticks for the slot being loaded
- load  in  1  single-cycle pulse (debounced set button); writes switches into slot[wr_ptr]
- start  in  1  single-cycle pulse; begins the sequence at slot 0
- stop  in  1  single-cycle pulse; aborts the sequence
- nslots  in  2  number of active slots minus 1 (0..3); sampled on start
- repeat  in  1  1 = wrap to slot 0 after the last active slot; sampled on start
- light  out  1  lamp drive, registered
- busy  out  1  1 while the sequence runs
- slot_idx  out  2  slot currently being timed
- wr_ptr  out  2  next slot load writes
- remaining  out  14  ticks left in the current slot, including the current one

## Operation
- Storage: slot[0..3], each 14 bits. load writes slot[wr_ptr] and increments wr_ptr mod 4. Loads are accepted in any state.
- FSM states IDLE and RUN.
- IDLE → RUN on start:
  - latch nslots and repeat
  - slot_idx=0, remaining=max(slot[0],1), prescaler=0
  - light=1, busy=1
- RUN, on tick with remaining>1: remaining decrements.
- RUN, on tick with remaining==1: advance.
  - If slot_idx<latched nslots: slot_idx+1 and remaining=max(slot[slot_idx+1],1).
  - Else, repeat latched 1: slot_idx=0 and remaining=max(slot[0],1).
  - Else: go to IDLE with light=0, busy=0, remaining=0, slot_idx=0.
- In RUN, light = ~slot_idx[0], updated in the same cycle slot_idx changes.
- A slot value of 0 is timed as 1 tick.
- stop in RUN → IDLE next edge: light=0, busy=0, remaining=0, slot_idx=0. stop in IDLE has no effect.
- start in RUN restarts exactly as from IDLE and re-latches nslots and repeat.
- Simultaneous events:
  - stop and start together: stop wins, result is IDLE.
  - load and start together: start uses the slot contents before the write; the write still completes.
  - A load into the slot being timed does not alter remaining. The new value applies the next time that slot is entered.
- remaining is 14-bit unsigned and never underflows.

## Timing
- Reset values: light=0, busy=0, slot_idx=0, wr_ptr=0, remaining=0, all slots=0, prescaler=0, state IDLE. Assertion clears all outputs immediately, with no clock edge required.
- Prescaler counts 0..TICK_DIV-1 only in RUN. tick is asserted for one cycle when the count equals TICK_DIV-1, and the count then wraps to 0.
- start → light, busy, remaining visible 1 cycle later.
- A slot of value N lasts exactly N·TICK_DIV cycles; value 0 lasts TICK_DIV cycles.
- Slot transition: new slot_idx, light and remaining all change on the same edge as the terminal tick. There is no dead cycle between slots.
- load → wr_ptr and slot contents update 1 cycle later.
- stop → busy=0 and light=0 1 cycle later.

## Test plan
All scenarios use TICK_DIV=4.
- Load 3 then 2; nslots=1, repeat=0; start. Required: wr_ptr=2; light=1 for 12 cycles, then 0 for 8 cycles; busy falls on the same edge the second slot ends; remaining reads 0 afterwards.
- Same loads with repeat=1. Required: light period is 20 cycles (12 high, 8 low), repeating. A stop 2 cycles into slot 1 gives busy=0, light=0, slot_idx=0 one cycle later.
- Load 0 into slot 0 and 5 into slot 1; nslots=1; start. Required: light high for exactly 4 cycles, then low for 20 cycles.
- start and stop in the same cycle while IDLE: busy stays 0. A start while in slot 1: slot_idx=0, light=1, remaining=slot[0] one cycle later.
- Drop reset mid-RUN between clock edges. Required: light=0, busy=0, remaining=0 immediately. After release, a start with nslots=0 times slot[0]=0 as 1 tick.
- Five consecutive loads of 1,2,3,4,9. Required: wr_ptr=1, slot[0]=9, slot[3]=4. A load in the same cycle as start does not affect the first remaining value.
